// File: rtl/rr_mux4_arbiter_pkg.sv
// rr_mux4_arbiter_pkg: shared state encoding and sizes for the round-robin mux4 arbiter
package rr_mux4_arbiter_pkg;
    localparam int REQ_N = 4;
    localparam int SEL_W = 2;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_mux4_arbiter_pick4.sv
// rr_pick4: first set request bit searching from ptr upward (mod 4)
module rr_pick4
    import rr_mux4_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx,
    output logic [REQ_N-1:0] onehot
);
    logic [2*REQ_N-1:0] dbl;
    logic [REQ_N-1:0]   rot;
    logic [SEL_W-1:0]   off;
    // rotate so bit 0 is the highest-priority requester
    always_comb begin
        dbl    = {req, req} >> ptr;
        rot    = dbl[REQ_N-1:0];
        off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        valid  = |req;
        idx    = ptr + off;
        onehot = valid ? REQ_N'(1) << idx : '0;
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin owner of a shared 4:1 32-bit mux with bounded bursts
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_N-1:0] req,
    input  logic [REQ_N-1:0] last,
    input  logic             ready,
    output logic [REQ_N-1:0] grant,
    output logic [SEL_W-1:0] select,
    output logic             valid,
    output logic             busy
);
    state_t             state, state_n;
    logic [REQ_N-1:0]   grant_n, idle_oh, rel_oh;
    logic [SEL_W-1:0]   select_n, ptr, ptr_n, idle_idx, rel_idx, rel_ptr;
    logic [CNT_W-1:0]   beat_cnt, cnt_n;
    logic               busy_n, idle_v, rel_v, beat, hit, rel;

    assign rel_ptr = select + 2'd1;

    rr_pick4 u_idle_pick (.req(req), .ptr(ptr), .valid(idle_v), .idx(idle_idx), .onehot(idle_oh));
    // the releasing owner is masked out so it cannot win its own handoff
    rr_pick4 u_rel_pick (.req(req & ~grant), .ptr(rel_ptr), .valid(rel_v), .idx(rel_idx), .onehot(rel_oh));

    always_comb begin
        valid    = busy & req[select];
        beat     = valid & ready;
        hit      = beat_cnt == CNT_W'(MAX_HOLD - 1);
        rel      = state == ST_GRANT && (!req[select] || (beat && (last[select] || hit)));
        state_n  = state;
        grant_n  = grant;
        select_n = select;
        busy_n   = busy;
        cnt_n    = beat_cnt;
        ptr_n    = ptr;
        if (state == ST_IDLE) begin
            if (idle_v) begin
                state_n  = ST_GRANT;
                select_n = idle_idx;
                grant_n  = idle_oh;
                busy_n   = 1'b1;
                cnt_n    = '0;
            end
        end else if (rel) begin
            ptr_n = rel_ptr;
            cnt_n = '0;
            if (rel_v) begin
                select_n = rel_idx;
                grant_n  = rel_oh;
            end else begin
                state_n = ST_IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
            end
        end else if (beat) begin
            cnt_n = beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            select   <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            select   <= select_n;
            busy     <= busy_n;
            beat_cnt <= cnt_n;
            ptr      <= ptr_n;
        end
    end
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: directed and random checks against an owner/pointer reference model
module tb_rr_mux4_arbiter;
    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0, last = '0;
    logic       ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] select;
    logic       valid, busy;

    int n_assert = 0;
    int n_fail = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_sel = 0;

    rr_mux4_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .last(last), .ready(ready),
        .grant(grant), .select(select), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    function automatic logic [7:0] exp_out();
        logic [3:0] g;
        g = (m_owner < 0) ? 4'b0000 : 4'b0001 << m_owner;
        return {g, 2'(m_sel), m_owner >= 0, m_owner >= 0 && req[m_owner]};
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
    endtask

    task automatic model_edge();
        int o, n;
        logic b, r;
        logic [3:0] masked;
        if (m_owner < 0) begin
            n = pick(req, m_ptr);
            if (n >= 0) begin m_owner = n; m_sel = n; m_cnt = 0; end
        end else begin
            o = m_owner;
            b = req[o] && ready;
            r = !req[o] || (b && (last[o] || m_cnt + 1 == MH));
            if (r) begin
                m_ptr = (o + 1) % 4;
                masked = req;
                masked[o] = 1'b0;
                n = pick(masked, m_ptr);
                m_owner = n;
                m_cnt = 0;
                if (n >= 0) m_sel = n;
            end else if (b) m_cnt++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; last = '0; ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++;
        if ({grant, select, busy, valid} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", {grant, select, busy, valid}, 8'h00);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; last = 4'b0001; ready = 1'b1;
        n_assert++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL single_req_cycle_valid: got %b want 0", valid); end
        tick();
        n_assert++;
        if ({grant, select, valid} !== 7'b0001_00_1) begin
            n_fail++; $display("FAIL single_grant: got %b want 0001001", {grant, select, valid});
        end
        tick();
        n_assert++;
        if ({busy, grant} !== 5'b0_0000) begin
            n_fail++; $display("FAIL single_release: got %b want 00000", {busy, grant});
        end
        // ptr is now 1, so with all requesting requester 1 wins
        req = 4'b1111; last = 4'b0000;
        tick();
        n_assert++;
        if (grant !== 4'b0010) begin n_fail++; $display("FAIL single_ptr_adv: got %b want 0010", grant); end
    endtask

    task automatic test_rotate();
        do_reset();
        req = 4'b1111; last = 4'b1111; ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_assert++;
            if ({select, busy, valid} !== {2'(k % 4), 2'b11} || {grant, select, busy, valid} !== exp_out()) begin
                n_fail++;
                $display("FAIL rotate[%0d]: got %b want sel %0d model %b", k, {grant, select, busy, valid}, k % 4, exp_out());
            end
        end
    endtask

    task automatic test_max_hold();
        do_reset();
        req = 4'b0011; last = 4'b0000; ready = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            n_assert++;
            if (select !== 2'(((e - 1) / MH) % 2) || {grant, select, busy, valid} !== exp_out()) begin
                n_fail++;
                $display("FAIL max_hold[%0d]: got %b want sel %0d model %b", e, {grant, select, busy, valid}, ((e - 1) / MH) % 2, exp_out());
            end
        end
    endtask

    task automatic test_ready_stall(input logic [3:0] after);
        do_reset();
        req = 4'b0100; last = 4'b0000; ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        req = 4'b0100 | after;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_assert++;
            if (grant !== 4'b0100 || {grant, select, busy, valid} !== exp_out()) begin
                n_fail++; $display("FAIL stall[%0d]: got %b want 0100 model %b", k, grant, exp_out());
            end
        end
        req = after;
        tick();
        n_assert++;
        if ({grant, busy} !== ((after == 4'b0000) ? 5'b0000_0 : 5'b0001_1) || {grant, select, busy, valid} !== exp_out()) begin
            n_fail++; $display("FAIL abandon: got %b model %b", {grant, select, busy, valid}, exp_out());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000; last = 4'b0000; ready = 1'b1;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        n_assert++;
        if ({grant, busy, valid} !== 6'b0) begin
            n_fail++; $display("FAIL async_reset: got %b want 000000", {grant, busy, valid});
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        req = 4'b1001;
        #1;
        tick();
        n_assert++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL post_reset_grant: got %b want 0001", grant); end
    endtask

    task automatic test_reacquire();
        logic [3:0] want [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
        do_reset();
        req = 4'b0010; last = 4'b0010; ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_assert++;
            if (grant !== want[k] || $countones(grant) > 1) begin
                n_fail++; $display("FAIL reacquire[%0d]: got %b want %b", k, grant, want[k]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            last  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            ready = $urandom_range(0, 3) != 0;
            #1;
            n_assert++;
            if ({grant, select, busy, valid} !== exp_out() || $countones(grant) > 1 ||
                (busy && grant !== 4'b0001 << select)) begin
                n_fail++; $display("FAIL random[%0d]: got %b want %b", k, {grant, select, busy, valid}, exp_out());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_max_hold();
        test_ready_stall(4'b0001);
        test_ready_stall(4'b0000);
        test_async_reset();
        test_reacquire();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
